fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded while reset is asserted.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 Port PCSrcE  input  1  redirect request from execute (taken branch/jump).
REQ-005 Port PCTargetE  input  32  redirect target, sampled when PCSrcE=1.
REQ-006 Port StallD  input  1  decode stage cannot accept a new instruction this cycle.
REQ-007 Port imem_req  output  1  instruction memory request valid.
REQ-008 Port imem_addr  output  32  instruction memory word address (byte address, bits [1:0]=0).
REQ-009 Port imem_ack  input  1  one-cycle response strobe; imem_rdata valid in the same cycle.
REQ-010 Port imem_rdata  input  32  fetched instruction word.
REQ-011 Port InstrD  output  32  instruction presented to decode.
REQ-012 Port PCD  output  32  PC of InstrD.
REQ-013 Port PCPlus4D  output  32  PCD+4.
REQ-014 Port ValidD  output  1  InstrD/PCD/PCPlus4D hold a live instruction.

Function
REQ-015 The block SHALL implement states IDLE, REQ, HOLD, KILL.
REQ-016 IDLE: imem_req=0; on the first rising edge with rst=1, SHALL go to REQ with imem_addr=PC.
REQ-017 REQ: imem_req=1; imem_addr and imem_req SHALL stay stable until imem_ack=1.
REQ-018 REQ, imem_ack=1, PCSrcE=0, (StallD=0 or ValidD=0): D-register SHALL load InstrD=imem_rdata, PCD=PC, PCPlus4D=PC+4, ValidD=1; PC<=PC+4; remain REQ; next request issued the following cycle (one-cycle bubble on imem_req permitted: no, imem_req SHALL stay 1 with the new address).
REQ-019 REQ, imem_ack=1, PCSrcE=0, StallD=1, ValidD=1: response SHALL be captured into a one-entry skid buffer (word, PC); PC<=PC+4; go HOLD; imem_req=0 in HOLD.
REQ-020 HOLD, StallD=0: buffer SHALL move into the D-register (ValidD=1); go REQ.
REQ-021 StallD=1 with ValidD=1 SHALL freeze InstrD, PCD, PCPlus4D, ValidD.
REQ-022 PCSrcE=1 in any state SHALL clear ValidD on the next edge (flush overrides StallD), discard the skid buffer, and set PC<=PCTargetE with bits [1:0] forced to 0.
REQ-023 PCSrcE=1 in REQ with imem_ack=0 SHALL go KILL; KILL keeps the original imem_addr and imem_req=1 until imem_ack, discards that response, then goes REQ at the redirected PC.
REQ-024 PCSrcE=1 in the same cycle as imem_ack SHALL discard imem_rdata and go REQ at the redirected PC next cycle.
REQ-025 PCSrcE=1 in KILL SHALL overwrite the pending target; the latest target wins.
REQ-026 PCSrcE=1 in IDLE or HOLD SHALL go REQ at the redirected PC.
REQ-027 PC+4 and PCPlus4D SHALL wrap modulo 2^32 (32'hFFFFFFFC+4 = 32'h00000000).
REQ-028 Only one request SHALL be outstanding; imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, ValidD=0, InstrD=0, PCD=0, PCPlus4D=0, skid buffer empty.
REQ-030 rst=0 mid-request SHALL abandon the request; an imem_ack following reset release without a new request SHALL be ignored.

Verification
REQ-031 Reset held 2 cycles, release, imem_ack every cycle after req -> imem_addr 0x0,0x4,0x8; PCD follows one cycle later with PCPlus4D=PCD+4, ValidD=1.
REQ-032 StallD=1 while ack for 0x8 arrives -> InstrD/PCD frozen at 0x4, state HOLD, imem_req=0; StallD=0 -> PCD=0x8 next cycle, then req 0xC.
REQ-033 PCSrcE=1, PCTargetE=0x100 while request 0x10 outstanding (ack 3 cycles later) -> imem_addr stays 0x10 until ack, ack data dropped, ValidD=0, next req 0x100.
REQ-034 PCSrcE=1, PCTargetE=0x203 coincident with ack and StallD=1 -> data dropped, ValidD=0 next edge, next imem_addr=0x200.
REQ-035 RESET_PC=32'hFFFFFFFC -> first req 0xFFFFFFFC, PCPlus4D=0x00000000, next req 0x00000000.
REQ-036 rst=0 asserted between clock edges during REQ -> imem_req, ValidD drop to 0 without a clock edge; stray ack after release ignored.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with one-entry skid buffer and redirect kill
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} stateType;

    stateType    state, stateNext;
    logic [31:0] pc, pcNext;
    logic [31:0] killAddr, killAddrNext;
    logic [31:0] skidInstr, skidInstrNext;
    logic [31:0] skidPc, skidPcNext;
    logic [31:0] instrDNext, pcDNext, pcPlus4DNext;
    logic        validDNext;
    logic [31:0] redirectPc;

    assign redirectPc = {PCTargetE[31:2], 2'b00};

    // KILL keeps presenting the abandoned address until its response drains.
    assign imem_req  = (state == REQ) || (state == KILL);
    assign imem_addr = (state == KILL) ? killAddr : pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            killAddr  <= 32'h0;
            skidInstr <= 32'h0;
            skidPc    <= 32'h0;
            InstrD    <= 32'h0;
            PCD       <= 32'h0;
            PCPlus4D  <= 32'h0;
            ValidD    <= 1'b0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            killAddr  <= killAddrNext;
            skidInstr <= skidInstrNext;
            skidPc    <= skidPcNext;
            InstrD    <= instrDNext;
            PCD       <= pcDNext;
            PCPlus4D  <= pcPlus4DNext;
            ValidD    <= validDNext;
        end
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        killAddrNext  = killAddr;
        skidInstrNext = skidInstr;
        skidPcNext    = skidPc;
        instrDNext    = InstrD;
        pcDNext       = PCD;
        pcPlus4DNext  = PCPlus4D;
        // Decode consumes the instruction unless stalled; a stalled one is frozen.
        validDNext    = ValidD && StallD;

        case (state)
            IDLE: begin
                stateNext = REQ;
                if (PCSrcE) begin
                    pcNext = redirectPc;
                end
            end
            REQ: begin
                if (PCSrcE) begin
                    pcNext = redirectPc;
                    if (!imem_ack) begin
                        killAddrNext = pc;
                        stateNext    = KILL;
                    end
                end else if (imem_ack) begin
                    pcNext = pc + 32'd4;
                    if (StallD && ValidD) begin
                        skidInstrNext = imem_rdata;
                        skidPcNext    = pc;
                        stateNext     = HOLD;
                    end else begin
                        instrDNext   = imem_rdata;
                        pcDNext      = pc;
                        pcPlus4DNext = pc + 32'd4;
                        validDNext   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcNext    = redirectPc;
                    stateNext = REQ;
                end else if (!StallD) begin
                    instrDNext   = skidInstr;
                    pcDNext      = skidPc;
                    pcPlus4DNext = skidPc + 32'd4;
                    validDNext   = 1'b1;
                    stateNext    = REQ;
                end
            end
            KILL: begin
                if (PCSrcE) begin
                    pcNext = redirectPc;
                end
                if (imem_ack) begin
                    stateNext = REQ;
                end
            end
            default: stateNext = IDLE;
        endcase

        // A flush always wins over a stall.
        if (PCSrcE) begin
            validDNext = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        wrapReq;
    logic [31:0] wrapAddr;
    logic        wrapAck;
    logic [31:0] wrapRdata;
    logic [31:0] wrapInstrD, wrapPCD, wrapPCPlus4D;
    logic        wrapValidD;
    logic        zeroBit;
    logic [31:0] zeroWord;

    int total = 0;
    int bad   = 0;

    logic [31:0] expAddr[$];
    logic [31:0] expD[$];

    int  ackDelay = 0;
    int  waitCnt  = 0;
    logic ackEn    = 1'b1;
    logic strayAck = 1'b0;
    logic prevValid = 1'b0;
    logic prevStall = 1'b0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFFFFFC)) wrapDut (
        .clk(clk), .rst(rst), .PCSrcE(zeroBit), .PCTargetE(zeroWord), .StallD(zeroBit),
        .imem_req(wrapReq), .imem_addr(wrapAddr), .imem_ack(wrapAck), .imem_rdata(wrapRdata),
        .InstrD(wrapInstrD), .PCD(wrapPCD), .PCPlus4D(wrapPCPlus4D), .ValidD(wrapValidD)
    );

    assign zeroBit   = 1'b0;
    assign zeroWord  = 32'h0;
    assign wrapAck   = wrapReq;
    assign wrapRdata = ~wrapAddr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'h13579BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acknowledges the current request after ackDelay waiting cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (strayAck) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEADBEEF;
            end else if (imem_req && ackEn) begin
                if (waitCnt == ackDelay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = instrOf(imem_addr);
                    waitCnt    = 0;
                end else begin
                    imem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                imem_ack = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted request and every new decode instruction.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                if (expAddr.size() == 0) begin
                    check("unexpected_ack_addr", imem_addr, 32'hXXXXXXXX);
                end else begin
                    e = expAddr.pop_front();
                    check("req_addr", imem_addr, e);
                end
            end
            if (ValidD && !(prevValid && prevStall)) begin
                if (expD.size() == 0) begin
                    check("unexpected_decode_pc", PCD, 32'hXXXXXXXX);
                end else begin
                    e = expD.pop_front();
                    check("decode_pc", PCD, e);
                    check("decode_instr", InstrD, instrOf(e));
                    check("decode_pcplus4", PCPlus4D, e + 32'd4);
                end
            end
            prevValid = ValidD;
            prevStall = StallD;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = 32'h0;
        StallD    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, ValidD}, 32'h0);
        check("rst_instr", InstrD, 32'h0);
        check("rst_pcd", PCD, 32'h0);
        check("rst_pcplus4", PCPlus4D, 32'h0);
        check("rst_wrap_addr", wrapAddr, 32'hFFFFFFFC);

        // Straight-line fetch, then stall while the 0x8 response lands.
        expAddr.push_back(32'h0);
        expAddr.push_back(32'h4);
        expAddr.push_back(32'h8);
        expAddr.push_back(32'hC);
        expD.push_back(32'h0);
        expD.push_back(32'h4);
        expD.push_back(32'h8);
        expD.push_back(32'hC);
        rst = 1'b1;
        @(posedge clk); #1;
        check("wrap_first_addr", wrapAddr, 32'hFFFFFFFC);
        check("wrap_first_req", {31'b0, wrapReq}, 32'h1);
        @(posedge clk); #1;
        check("wrap_pcd", wrapPCD, 32'hFFFFFFFC);
        check("wrap_pcplus4", wrapPCPlus4D, 32'h0);
        check("wrap_instr", wrapInstrD, 32'h00000003);
        check("wrap_next_addr", wrapAddr, 32'h0);

        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(imem_req && imem_addr == 32'h8) && n < 40);
        check("wait_req_8", {31'b0, imem_req && imem_addr == 32'h8}, 32'h1);
        StallD = 1'b1;
        @(posedge clk); #1;
        check("hold_req", {31'b0, imem_req}, 32'h0);
        check("hold_pcd", PCD, 32'h4);
        check("hold_valid", {31'b0, ValidD}, 32'h1);
        @(posedge clk); #1;
        check("hold2_req", {31'b0, imem_req}, 32'h0);
        check("hold2_pcd", PCD, 32'h4);
        StallD = 1'b0;
        @(posedge clk); #1;
        check("unhold_pcd", PCD, 32'h8);
        check("unhold_req", {31'b0, imem_req}, 32'h1);
        check("unhold_addr", imem_addr, 32'hC);

        // Redirect while a slow request is outstanding.
        ackDelay = 3;
        expAddr.push_back(32'h10);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(imem_req && imem_addr == 32'h10) && n < 40);
        check("wait_req_10", {31'b0, imem_req && imem_addr == 32'h10}, 32'h1);
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        @(posedge clk); #1;
        PCSrcE = 1'b0;
        check("kill_addr", imem_addr, 32'h10);
        check("kill_req", {31'b0, imem_req}, 32'h1);
        check("kill_valid", {31'b0, ValidD}, 32'h0);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(imem_req && imem_addr == 32'h100) && n < 40);
        check("wait_req_100", {31'b0, imem_req && imem_addr == 32'h100}, 32'h1);
        check("after_kill_valid", {31'b0, ValidD}, 32'h0);

        // Redirect coincident with an ack under stall; unaligned target.
        ackDelay = 0;
        expAddr.push_back(32'h100);
        expAddr.push_back(32'h104);
        expAddr.push_back(32'h200);
        expD.push_back(32'h100);
        expD.push_back(32'h200);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(imem_req && imem_addr == 32'h104) && n < 40);
        check("wait_req_104", {31'b0, imem_req && imem_addr == 32'h104}, 32'h1);
        StallD    = 1'b1;
        PCSrcE    = 1'b1;
        PCTargetE = 32'h203;
        @(posedge clk); #1;
        PCSrcE = 1'b0;
        StallD = 1'b0;
        check("flush_valid", {31'b0, ValidD}, 32'h0);
        check("flush_addr", imem_addr, 32'h200);
        check("flush_req", {31'b0, imem_req}, 32'h1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!(ValidD && PCD == 32'h200) && n < 40);
        check("wait_decode_200", {31'b0, ValidD && PCD == 32'h200}, 32'h1);
        ackEn  = 1'b0;
        StallD = 1'b1;

        // Asynchronous reset between edges, then a stray ack while idle.
        @(posedge clk); #1;
        check("pre_rst_valid", {31'b0, ValidD}, 32'h1);
        check("pre_rst_req", {31'b0, imem_req}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req", {31'b0, imem_req}, 32'h0);
        check("async_rst_valid", {31'b0, ValidD}, 32'h0);
        check("async_rst_addr", imem_addr, 32'h0);
        check("async_rst_pcd", PCD, 32'h0);
        @(posedge clk); #1;
        rst      = 1'b1;
        StallD   = 1'b0;
        strayAck = 1'b1;
        @(posedge clk); #1;
        strayAck = 1'b0;
        check("post_rst_req", {31'b0, imem_req}, 32'h1);
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_valid", {31'b0, ValidD}, 32'h0);
        @(posedge clk); #1;
        check("stray_ignored_valid", {31'b0, ValidD}, 32'h0);
        check("stray_ignored_addr", imem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("addr_queue_drained", expAddr.size(), 32'h0);
        check("decode_queue_drained", expD.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
